// File: rtl/sort_mem_responder.sv
//------------------------------------------------------------------------------
// sort_mem_responder
//
// Memory-side responder for the sort datapath's request/valid memory port.
// Holds the array being sorted and serves one read or write at a time. Every
// accepted request gets exactly one response pulse after a fixed latency.
// Errors are flagged on o_err but never suppress the response pulse, so the
// initiator cannot hang. A backdoor load port preloads unsorted data.
//
// State table
//   state  | meaning
//   IDLE   | waiting for a request; a held request is accepted here
//   BUSY   | latency countdown, request inputs ignored
//   RESP   | response pulse cycle; always followed by one IDLE cycle
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rd_en, i_wr_en          request levels, held until the matching pulse
//   i_addr, i_wdata           request address / write data
//   o_rdata                   read data, held until the next read response
//   o_valid_rd, o_valid_wr    one-cycle completion pulses
//   o_busy                    high while in BUSY or RESP
//   o_err                     pulses with the response of a bad request
//   i_ld_en/addr/data         backdoor write port, usable in any state
//------------------------------------------------------------------------------
module sort_mem_responder #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 16,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd_en,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_valid_rd,
  output logic              o_valid_wr,
  output logic              o_busy,
  output logic              o_err,
  input  logic              i_ld_en,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_data
);

  localparam int               IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]       LP_RD_CNT = 4'(RD_LAT - 1);
  localparam logic [3:0]       LP_WR_CNT = 4'(WR_LAT - 1);
  localparam logic [ADDR_W:0]  LP_DEPTH  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic [3:0]          w_cnt_nxt;
  logic                w_enter_resp;

  // latched request
  logic                r_is_wr;
  logic                r_oor;
  logic                r_bad;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  // registered outputs
  logic [DATA_W-1:0]   r_rdata;
  logic                r_valid_rd;
  logic                r_valid_wr;
  logic                r_busy;
  logic                r_err;

  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_req;
  logic                w_in_oor;
  logic                w_in_bad;
  logic                w_in_lat1;
  logic                w_ld_oor;

  logic                w_txn_wr;
  logic                w_txn_oor;
  logic                w_txn_bad;
  logic [ADDR_W-1:0]   w_txn_addr;
  logic [DATA_W-1:0]   w_txn_wdata;
  logic [IDX_W-1:0]    w_txn_idx;
  logic                w_commit;

  assign w_req     = i_rd_en | i_wr_en;
  assign w_in_oor  = ({1'b0, i_addr} >= LP_DEPTH);
  // both enables high is served as a write but still flagged
  assign w_in_bad  = w_in_oor | (i_rd_en & i_wr_en);
  assign w_in_lat1 = i_wr_en ? (WR_LAT == 1) : (RD_LAT == 1);
  assign w_ld_oor  = ({1'b0, i_ld_addr} >= LP_DEPTH);

  // With a latency of 1 the FSM goes IDLE -> RESP on the accepting edge, so
  // the transaction has not been latched yet; take it from the inputs then.
  always_comb begin
    w_txn_wr    = r_is_wr;
    w_txn_oor   = r_oor;
    w_txn_bad   = r_bad;
    w_txn_addr  = r_addr;
    w_txn_wdata = r_wdata;
    if (r_state == S_IDLE) begin
      w_txn_wr    = i_wr_en;
      w_txn_oor   = w_in_oor;
      w_txn_bad   = w_in_bad;
      w_txn_addr  = i_addr;
      w_txn_wdata = i_wdata;
    end
  end

  assign w_txn_idx = w_txn_addr[IDX_W-1:0];

  // Counter is loaded with LAT-1 and the move to RESP happens on the edge
  // where it reaches zero, which places RESP exactly LAT cycles after accept.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_cnt_nxt = i_wr_en ? LP_WR_CNT : LP_RD_CNT;
          if (w_in_lat1) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_cnt_nxt    = 4'd0;
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_is_wr    <= 1'b0;
      r_oor      <= 1'b0;
      r_bad      <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_valid_rd <= 1'b0;
      r_valid_wr <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == S_IDLE) && w_req) begin
        r_is_wr <= i_wr_en;
        r_oor   <= w_in_oor;
        r_bad   <= w_in_bad;
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      r_valid_rd <= w_enter_resp & ~w_txn_wr;
      r_valid_wr <= w_enter_resp &  w_txn_wr;
      r_err      <= w_enter_resp &  w_txn_bad;
      r_busy     <= (w_state_nxt != S_IDLE);
      if (w_enter_resp && !w_txn_wr) begin
        r_rdata <= w_txn_oor ? '0 : r_mem[w_txn_idx];
      end
    end
  end

  // Reset gates the commit so a write pending at reset is never written.
  assign w_commit = i_rst_n & w_enter_resp & w_txn_wr & ~w_txn_oor;

  // Array is not reset. The front-door commit is written last so it wins a
  // same-cycle, same-address collision with the backdoor.
  always_ff @(posedge i_clk) begin
    if (i_ld_en && !w_ld_oor) begin
      r_mem[i_ld_addr[IDX_W-1:0]] <= i_ld_data;
    end
    if (w_commit) begin
      r_mem[w_txn_idx] <= w_txn_wdata;
    end
  end

  assign o_rdata    = r_rdata;
  assign o_valid_rd = r_valid_rd;
  assign o_valid_wr = r_valid_wr;
  assign o_busy     = r_busy;
  assign o_err      = r_err;

endmodule
